// File: rtl/slice_assembler.sv
// slice_assembler: packs a stream of SLICE_W-bit words into an
// NSLICE*SLICE_W-bit vector and presents the finished vector to a
// valid/ready consumer. It supports LSB-first or MSB-first fill order.
// A vector may be cut short with i_last; slices that were never written
// keep the fill pattern (all zeros or all ones).
module slice_assembler #(
  parameter int SLICE_W   = 4,
  parameter int NSLICE    = 2,
  parameter int MSB_FIRST = 0,
  parameter int FILL_ONES = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [SLICE_W-1:0]                i_data,
  input  logic                              i_valid,
  input  logic                              i_last,
  output logic                              o_ready,
  output logic [NSLICE*SLICE_W-1:0]         o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [$clog2(NSLICE+1)-1:0]       o_count,
  output logic                              o_short
);

  localparam int W  = NSLICE * SLICE_W;
  localparam int CW = $clog2(NSLICE + 1);
  localparam logic [W-1:0]  FILL_PAT = (FILL_ONES != 0) ? {W{1'b1}} : {W{1'b0}};
  localparam logic [CW-1:0] NS_C     = CW'(NSLICE);

  typedef enum logic {FILL, HOLD} state_t;

  state_t          state_reg;
  logic [CW-1:0]   k_reg;
  logic [W-1:0]    data_reg;
  logic [CW-1:0]   count_reg;
  logic            short_reg;

  logic            in_acc;
  logic            out_acc;
  logic            done;
  logic [CW-1:0]   k_eff;
  logic [CW-1:0]   k_inc;
  logic [CW-1:0]   slice_idx;
  logic [W-1:0]    base_vec;
  logic [W-1:0]    wr_vec;

  // Ready depends only on state and downstream ready, never on i_valid.
  assign o_ready = (state_reg == FILL) || i_ready;
  assign in_acc  = i_valid && o_ready;
  assign out_acc = (state_reg == HOLD) && i_ready;

  // In HOLD, an incoming word always starts a fresh vector (word 0 over the fill pattern).
  assign k_eff     = (state_reg == HOLD) ? '0 : k_reg;
  assign base_vec  = (state_reg == HOLD) ? FILL_PAT : data_reg;
  assign k_inc     = k_eff + 1'b1;
  assign slice_idx = (MSB_FIRST != 0) ? (NS_C - CW'(1) - k_eff) : k_eff;
  assign done      = (k_inc == NS_C) || i_last;

  // Candidate vector: the incoming word dropped into its slice, others kept.
  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign wr_vec[gi*SLICE_W +: SLICE_W] =
        (slice_idx == CW'(gi)) ? i_data : base_vec[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  // Gather/present FSM with registered vector, count and short flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= FILL;
      k_reg     <= '0;
      data_reg  <= FILL_PAT;
      count_reg <= '0;
      short_reg <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (in_acc) begin
            data_reg <= wr_vec;
            if (done) begin
              state_reg <= HOLD;
              k_reg     <= '0;
              count_reg <= k_inc;
              short_reg <= (k_inc < NS_C);
            end else begin
              k_reg <= k_inc;
            end
          end
        end
        HOLD: begin
          if (out_acc) begin
            if (in_acc) begin
              // Back-to-back: the new word opens the next vector with no bubble.
              data_reg <= wr_vec;
              if (done) begin
                k_reg     <= '0;
                count_reg <= k_inc;
                short_reg <= (k_inc < NS_C);
              end else begin
                state_reg <= FILL;
                k_reg     <= k_inc;
              end
            end else begin
              state_reg <= FILL;
              k_reg     <= '0;
              data_reg  <= FILL_PAT;
            end
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign o_valid = (state_reg == HOLD);
  assign o_data  = data_reg;
  assign o_count = count_reg;
  assign o_short = short_reg;

endmodule

// File: tb/tb_slice_assembler.sv
// Testbench for slice_assembler: six instances with different geometry,
// fill order and fill pattern. A reference model pushes expected vectors
// into per-instance queues; a monitor pops and compares on each output accept.
// Directed cases also check hand-computed constants.
module tb_slice_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NI = 6;

  logic        rst;
  logic        iv   [NI];
  logic        il   [NI];
  logic        ir   [NI];
  logic [7:0]  idat [NI];
  logic        ov   [NI];
  logic        ordy [NI];
  logic        os   [NI];
  logic [31:0] od   [NI];
  logic [2:0]  oc   [NI];

  // pending stimulus, applied just after the next rising edge
  logic        prst;
  logic        pv [NI];
  logic        pl [NI];
  logic        pr [NI];
  logic [7:0]  pd [NI];

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  cnt;
    logic        sh;
  } exp_t;

  exp_t        q [NI][$];
  int          mk    [NI];
  logic [31:0] mbuf  [NI];
  bit          mhold [NI];
  int          nvec  [NI];

  // instance geometry: 0,1 = 4x2 (LSB-first, MSB-first); 2..5 = 8x4 with (MSB,FILL) = 00,10,01,11
  function automatic int f_sw(int id);   return (id < 2) ? 4 : 8; endfunction
  function automatic int f_ns(int id);   return (id < 2) ? 2 : 4; endfunction
  function automatic int f_msb(int id);  return (id < 2) ? id : (id - 2) % 2; endfunction
  function automatic int f_fill(int id); return (id < 2) ? 0 : (id - 2) / 2; endfunction
  function automatic logic [31:0] f_pat(int id);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    return (f_fill(id) != 0) ? (ones >> (32 - f_sw(id) * f_ns(id))) : 32'h0;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      localparam int SW  = (gi < 2) ? 4 : 8;
      localparam int NS  = (gi < 2) ? 2 : 4;
      localparam int MSB = (gi < 2) ? gi : (gi - 2) % 2;
      localparam int FL  = (gi < 2) ? 0 : (gi - 2) / 2;
      localparam int CW  = $clog2(NS + 1);
      logic [SW*NS-1:0] odat;
      logic [CW-1:0]    ocnt;
      slice_assembler #(
        .SLICE_W(SW), .NSLICE(NS), .MSB_FIRST(MSB), .FILL_ONES(FL)
      ) u_dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (idat[gi][SW-1:0]),
        .i_valid (iv[gi]),
        .i_last  (il[gi]),
        .o_ready (ordy[gi]),
        .o_data  (odat),
        .o_valid (ov[gi]),
        .i_ready (ir[gi]),
        .o_count (ocnt),
        .o_short (os[gi])
      );
      assign od[gi] = 32'(odat);
      assign oc[gi] = 3'(ocnt);
    end
  endgenerate

  // model + monitor: one process evaluates every instance at the falling edge
  logic er;
  exp_t e;
  int   idx;
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        mk[i]    = 0;
        mhold[i] = 1'b0;
        q[i].delete();
      end else begin
        er = !mhold[i] || ir[i];
        checks++;
        if (ordy[i] !== er) begin
          fails++;
          $display("FAIL ready inst %0d t=%0t: got %b expected %b", i, $time, ordy[i], er);
        end
        checks++;
        if (ov[i] !== mhold[i]) begin
          fails++;
          $display("FAIL valid inst %0d t=%0t: got %b expected %b", i, $time, ov[i], mhold[i]);
        end
        if (ov[i] && ir[i]) begin
          checks++;
          if (q[i].size() == 0) begin
            fails++;
            $display("FAIL unexpected_out inst %0d: got data=%h, expected no vector", i, od[i]);
          end else begin
            e = q[i].pop_front();
            nvec[i]++;
            if (od[i] !== e.data || oc[i] !== e.cnt || os[i] !== e.sh) begin
              fails++;
              $display("FAIL vector inst %0d: got data=%h cnt=%0d short=%b expected data=%h cnt=%0d short=%b",
                       i, od[i], oc[i], os[i], e.data, e.cnt, e.sh);
            end else begin
              $display("inst %0d out data=%h cnt=%0d short=%b", i, od[i], oc[i], os[i]);
            end
          end
        end
        if (mhold[i] && ir[i]) mhold[i] = 1'b0;
        if (iv[i] && er) begin
          if (mk[i] == 0) mbuf[i] = f_pat(i);
          idx = (f_msb(i) != 0) ? f_ns(i) - 1 - mk[i] : mk[i];
          for (int b = 0; b < f_sw(i); b++) mbuf[i][idx * f_sw(i) + b] = idat[i][b];
          mk[i]++;
          if (mk[i] == f_ns(i) || il[i]) begin
            e.data = mbuf[i];
            e.cnt  = 3'(mk[i]);
            e.sh   = (mk[i] < f_ns(i));
            q[i].push_back(e);
            mhold[i] = 1'b1;
            mk[i]    = 0;
          end
        end
      end
    end
  end

  task automatic setin(int id, logic v, logic [7:0] d, logic l, logic r);
    pv[id] = v; pd[id] = d; pl[id] = l; pr[id] = r;
  endtask

  task automatic idle(int id);
    setin(id, 1'b0, 8'h0, 1'b0, 1'b1);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    rst = prst;
    for (int i = 0; i < NI; i++) begin
      iv[i] = pv[i]; idat[i] = pd[i]; il[i] = pl[i]; ir[i] = pr[i];
    end
    @(negedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end else begin
      $display("check %s = %h", nm, got);
    end
  endtask

  initial begin
    prst = 1'b1;
    rst  = 1'b1;
    for (int i = 0; i < NI; i++) begin
      idle(i);
      iv[i] = 1'b0; idat[i] = 8'h0; il[i] = 1'b0; ir[i] = 1'b1;
      nvec[i] = 0;
    end
    cyc();
    cyc();
    prst = 1'b0;
    cyc();
    // reset values
    chk("reset_data0", od[0], 32'h0);
    chk("reset_data4", od[4], 32'hFFFF_FFFF);
    chk("reset_count0", 32'(oc[0]), 32'd0);
    chk("reset_short0", 32'(os[0]), 32'd0);
    chk("reset_valid0", 32'(ov[0]), 32'd0);
    chk("reset_ready0", 32'(ordy[0]), 32'd1);

    // two nibbles, both fill orders
    setin(0, 1'b1, 8'h0, 1'b0, 1'b1); setin(1, 1'b1, 8'h0, 1'b0, 1'b1);
    cyc();
    setin(0, 1'b1, 8'hF, 1'b0, 1'b1); setin(1, 1'b1, 8'hF, 1'b0, 1'b1);
    cyc();
    idle(0); idle(1);
    cyc();
    chk("lsb_first_data", od[0], 32'hF0);
    chk("lsb_first_count", 32'(oc[0]), 32'd2);
    chk("lsb_first_short", 32'(os[0]), 32'd0);
    chk("lsb_first_valid", 32'(ov[0]), 32'd1);
    chk("msb_first_data", od[1], 32'h0F);
    cyc();
    chk("valid_one_cycle", 32'(ov[0]), 32'd0);

    // early termination with ones fill
    setin(4, 1'b1, 8'hAA, 1'b1, 1'b1);
    cyc();
    idle(4);
    cyc();
    chk("short_data", od[4], 32'hFFFF_FFAA);
    chk("short_count", 32'(oc[4]), 32'd1);
    chk("short_flag", 32'(os[4]), 32'd1);

    // backpressure then zero-bubble restart
    setin(0, 1'b1, 8'h5, 1'b0, 1'b0);
    cyc();
    setin(0, 1'b1, 8'h6, 1'b0, 1'b0);
    cyc();
    setin(0, 1'b0, 8'h0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("bp_ready_low", 32'(ordy[0]), 32'd0);
      chk("bp_data_stable", od[0], 32'h65);
    end
    setin(0, 1'b1, 8'h3, 1'b0, 1'b1);
    cyc();
    chk("bp_release_ready", 32'(ordy[0]), 32'd1);
    setin(0, 1'b1, 8'h4, 1'b0, 1'b1);
    cyc();
    idle(0);
    cyc();
    chk("bp_next_data", od[0], 32'h43);
    chk("bp_next_count", 32'(oc[0]), 32'd2);

    // reset mid-vector, then a full vector with i_last on the final slice
    setin(2, 1'b1, 8'h11, 1'b0, 1'b1);
    cyc();
    idle(2);
    prst = 1'b1;
    cyc();
    prst = 1'b0;
    setin(2, 1'b1, 8'h01, 1'b0, 1'b1); cyc();
    setin(2, 1'b1, 8'h02, 1'b0, 1'b1); cyc();
    setin(2, 1'b1, 8'h03, 1'b0, 1'b1); cyc();
    setin(2, 1'b1, 8'h04, 1'b1, 1'b1); cyc();
    idle(2);
    cyc();
    chk("rst_data", od[2], 32'h0403_0201);
    chk("rst_count", 32'(oc[2]), 32'd4);
    chk("rst_last_full_short", 32'(os[2]), 32'd0);

    // random streaming on all instances
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NI; i++) begin
        setin(i, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 4) == 0,
              $urandom_range(0, 3) != 0);
      end
      cyc();
    end
    for (int i = 0; i < NI; i++) idle(i);
    repeat (4) cyc();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("drain_empty_%0d", i), 32'(q[i].size()), 32'd0);
      checks++;
      if (nvec[i] < 20) begin
        fails++;
        $display("FAIL stream_volume inst %0d: got %0d vectors, expected at least 20", i, nvec[i]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
